// File: rtl/dram_cmd_timer_if.sv
// Command handshake between the DRAM controller (master) and the command timer (slave).
interface dram_cmd_timer_if #(
   parameter int unsigned NUM_OF_BANKS = 8,
   parameter int unsigned NUM_OF_ROWS  = 128,
   parameter int unsigned NUM_OF_COLS  = 8
) ();

   logic                    cmd_req;
   logic [1:0]              cmd;
   logic [NUM_OF_BANKS-1:0] bank_sel;
   logic [NUM_OF_ROWS-1:0]  row_sel;
   logic [NUM_OF_COLS-1:0]  col_sel;
   logic                    cmd_ack;
   logic                    cmd_err;

   modport master (
      output cmd_req, cmd, bank_sel, row_sel, col_sel,
      input  cmd_ack, cmd_err
   );

   modport slave (
      input  cmd_req, cmd, bank_sel, row_sel, col_sel,
      output cmd_ack, cmd_err
   );

endinterface

// File: rtl/dram_cmd_timer.sv
// Per-bank DRAM timing gate: acknowledges ACT/RD/WR/PRE once tRCD/tRAS/tRP and the
// shared burst window allow, tracks open rows and drives the serial data window.
module dram_cmd_timer #(
   parameter int unsigned NUM_OF_BANKS = 8,
   parameter int unsigned NUM_OF_ROWS  = 128,
   parameter int unsigned NUM_OF_COLS  = 8,
   parameter int unsigned T_RCD        = 4,
   parameter int unsigned T_RAS        = 10,
   parameter int unsigned T_RP         = 4,
   parameter int unsigned T_BURST      = 8
) (
   input  logic                    clk,
   input  logic                    rst_b,
   dram_cmd_timer_if.slave         bus,
   output logic [NUM_OF_BANKS-1:0] bank_open,
   output logic                    data_en,
   output logic                    data_wr,
   output logic                    all_idle
);

   localparam int unsigned BANK_W  = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
   localparam int unsigned ROW_W   = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
   localparam int unsigned T_MAX_A = (T_RCD > T_RAS) ? T_RCD : T_RAS;
   localparam int unsigned T_MAX_B = (T_RP > T_BURST) ? T_RP : T_BURST;
   localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int unsigned CNT_W   = $clog2(T_MAX + 2);
   localparam int unsigned WIN_W   = $clog2(T_BURST + 1);

   // A counter loaded on entry to the ack cycle A reads zero from A+T-1, so the
   // dependent check at A+T-1 acks no earlier than A+T.
   localparam logic [CNT_W-1:0] RCD_LD   = CNT_W'((T_RCD > 0) ? T_RCD - 1 : 0);
   localparam logic [CNT_W-1:0] RAS_LD   = CNT_W'((T_RAS > 0) ? T_RAS - 1 : 0);
   localparam logic [CNT_W-1:0] RP_LD    = CNT_W'((T_RP > 0) ? T_RP - 1 : 0);
   localparam logic [CNT_W-1:0] BURST_LD = CNT_W'((T_BURST > 0) ? T_BURST - 1 : 0);
   localparam logic [WIN_W-1:0] WIN_LD   = WIN_W'(T_BURST);

   localparam logic [1:0] CMD_ACT = 2'b00;
   localparam logic [1:0] CMD_RD  = 2'b01;
   localparam logic [1:0] CMD_WR  = 2'b10;
   localparam logic [1:0] CMD_PRE = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ACK, S_GAP} state_t;

   state_t                    state, state_nxt;
   logic [1:0]                cmd_q;
   logic [BANK_W-1:0]         bank_q;
   logic [ROW_W-1:0]          row_q;
   logic                      bank_ok_q, row_ok_q, col_ok_q;
   logic [ROW_W-1:0]          open_row     [NUM_OF_BANKS];
   logic [ROW_W-1:0]          open_row_nxt [NUM_OF_BANKS];
   logic [CNT_W-1:0]          rcd [NUM_OF_BANKS], rcd_nxt [NUM_OF_BANKS];
   logic [CNT_W-1:0]          ras [NUM_OF_BANKS], ras_nxt [NUM_OF_BANKS];
   logic [CNT_W-1:0]          rp  [NUM_OF_BANKS], rp_nxt  [NUM_OF_BANKS];
   logic [CNT_W-1:0]          burst, burst_nxt;
   logic [WIN_W-1:0]          win_cnt;
   logic [NUM_OF_BANKS-1:0]   bank_open_nxt;
   logic                      ack_nxt, err_nxt, all_idle_nxt;
   logic [BANK_W-1:0]         bank_idx;
   logic [ROW_W-1:0]          row_idx;
   logic                      is_rw, illegal, ready;

   // One-hot to index for the incoming bank/row selects.
   always_comb begin
      bank_idx = '0;
      row_idx  = '0;
      for (int unsigned i = 0; i < NUM_OF_BANKS; i++)
         if (bus.bank_sel[i]) bank_idx = BANK_W'(i);
      for (int unsigned i = 0; i < NUM_OF_ROWS; i++)
         if (bus.row_sel[i]) row_idx = ROW_W'(i);
   end

   // Legality and timing readiness of the captured command.
   always_comb begin
      is_rw   = (cmd_q == CMD_RD) || (cmd_q == CMD_WR);
      illegal = !bank_ok_q
              || ((cmd_q != CMD_PRE) && !row_ok_q)
              || (is_rw && !col_ok_q)
              || ((cmd_q == CMD_ACT) && bank_open[bank_q])
              || (is_rw && !bank_open[bank_q])
              || (is_rw && (open_row[bank_q] != row_q));
      case (cmd_q)
         CMD_ACT: ready = (rp[bank_q] == '0);
         CMD_PRE: ready = !bank_open[bank_q] || (ras[bank_q] == '0);
         default: ready = (rcd[bank_q] == '0) && (burst == '0);
      endcase
   end

   // Next state, ack/err and bank/counter updates applied on entry to S_ACK.
   always_comb begin
      state_nxt     = state;
      ack_nxt       = 1'b0;
      err_nxt       = 1'b0;
      bank_open_nxt = bank_open;
      open_row_nxt  = open_row;
      burst_nxt     = (burst != '0) ? burst - CNT_W'(1) : '0;
      for (int unsigned b = 0; b < NUM_OF_BANKS; b++) begin
         rcd_nxt[b] = (rcd[b] != '0) ? rcd[b] - CNT_W'(1) : '0;
         ras_nxt[b] = (ras[b] != '0) ? ras[b] - CNT_W'(1) : '0;
         rp_nxt[b]  = (rp[b]  != '0) ? rp[b]  - CNT_W'(1) : '0;
      end
      case (state)
         S_IDLE: begin
            if (bus.cmd_req) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (illegal) begin
               state_nxt = S_ACK;
               ack_nxt   = 1'b1;
               err_nxt   = 1'b1;
            end else if (ready) begin
               state_nxt = S_ACK;
               ack_nxt   = 1'b1;
               case (cmd_q)
                  CMD_ACT: begin
                     bank_open_nxt[bank_q] = 1'b1;
                     open_row_nxt[bank_q]  = row_q;
                     rcd_nxt[bank_q]       = RCD_LD;
                     ras_nxt[bank_q]       = RAS_LD;
                  end
                  CMD_PRE: begin
                     if (bank_open[bank_q]) begin
                        bank_open_nxt[bank_q] = 1'b0;
                        rp_nxt[bank_q]        = RP_LD;
                     end
                  end
                  default: burst_nxt = BURST_LD;
               endcase
            end
         end
         S_ACK:   state_nxt = S_GAP;
         default: state_nxt = S_IDLE;
      endcase
      all_idle_nxt = (bank_open_nxt == '0) && (burst_nxt == '0);
   end

   // State, bank bookkeeping, timing counters and handshake outputs.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= S_IDLE;
         bank_open <= '0;
         burst     <= '0;
         all_idle  <= 1'b1;
         bus.cmd_ack <= 1'b0;
         bus.cmd_err <= 1'b0;
         for (int unsigned b = 0; b < NUM_OF_BANKS; b++) begin
            open_row[b] <= '0;
            rcd[b]      <= '0;
            ras[b]      <= '0;
            rp[b]       <= '0;
         end
      end else begin
         state       <= state_nxt;
         bank_open   <= bank_open_nxt;
         burst       <= burst_nxt;
         all_idle    <= all_idle_nxt;
         bus.cmd_ack <= ack_nxt;
         bus.cmd_err <= err_nxt;
         open_row    <= open_row_nxt;
         rcd         <= rcd_nxt;
         ras         <= ras_nxt;
         rp          <= rp_nxt;
      end
   end

   // Command capture; inputs are ignored outside S_IDLE.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cmd_q     <= CMD_ACT;
         bank_q    <= '0;
         row_q     <= '0;
         bank_ok_q <= 1'b0;
         row_ok_q  <= 1'b0;
         col_ok_q  <= 1'b0;
      end else if ((state == S_IDLE) && bus.cmd_req) begin
         cmd_q     <= bus.cmd;
         bank_q    <= bank_idx;
         row_q     <= row_idx;
         bank_ok_q <= $onehot(bus.bank_sel);
         row_ok_q  <= $onehot(bus.row_sel);
         col_ok_q  <= $onehot(bus.col_sel);
      end
   end

   // Serial data window: T_BURST cycles starting the cycle after a RD/WR ack.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         win_cnt <= '0;
         data_en <= 1'b0;
         data_wr <= 1'b0;
      end else if ((state == S_ACK) && !bus.cmd_err && is_rw) begin
         win_cnt <= WIN_LD;
         data_en <= 1'b1;
         data_wr <= (cmd_q == CMD_WR);
      end else if (win_cnt != '0) begin
         win_cnt <= win_cnt - WIN_W'(1);
         data_en <= (win_cnt > WIN_W'(1));
      end
   end

endmodule

// File: tb/tb_dram_cmd_timer.sv
// Randomized self-checking bench for dram_cmd_timer against a cycle-time reference model.
module tb_dram_cmd_timer;

   localparam int unsigned NB      = 8;
   localparam int unsigned NR      = 128;
   localparam int unsigned NC      = 8;
   localparam int          T_RCD   = 4;
   localparam int          T_RAS   = 10;
   localparam int          T_RP    = 4;
   localparam int          T_BURST = 8;

   localparam logic [1:0] C_ACT = 2'b00;
   localparam logic [1:0] C_RD  = 2'b01;
   localparam logic [1:0] C_WR  = 2'b10;
   localparam logic [1:0] C_PRE = 2'b11;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic [NB-1:0] bank_open;
   logic          data_en, data_wr, all_idle;
   int            cyc = 0;

   dram_cmd_timer_if #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus ();

   dram_cmd_timer #(
      .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
      .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .T_BURST(T_BURST)
   ) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .bus       (bus),
      .bank_open (bank_open),
      .data_en   (data_en),
      .data_wr   (data_wr),
      .all_idle  (all_idle)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: absolute ack times per bank and for the data bus.
   bit m_open [NB];
   int m_row  [NB];
   int t_act  [NB];
   int t_pre  [NB];
   int t_rw, t_rw_prev;
   bit wr_last, wr_prev;
   bit pend, p_err;
   int p_bank, p_row, exp_ack;
   logic [1:0] p_cmd;
   int cur, idle_from;
   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int oh_idx(input logic [127:0] v);
      for (int i = 0; i < 128; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [NB-1:0] oh_b(input int i);
      logic [NB-1:0] v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [NR-1:0] oh_r(input int i);
      logic [NR-1:0] v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [NC-1:0] oh_c(input int i);
      logic [NC-1:0] v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [NB-1:0] open_vec();
      logic [NB-1:0] v = '0;
      for (int b = 0; b < NB; b++) v[b] = m_open[b];
      return v;
   endfunction

   function automatic bit in_win(input int t, input int c);
      return (c >= t + 1) && (c <= t + T_BURST);
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         m_open[b] = 1'b0;
         m_row[b]  = -1;
         t_act[b]  = -1000;
         t_pre[b]  = -1000;
      end
      t_rw      = -1000;
      t_rw_prev = -1000;
      wr_last   = 1'b0;
      wr_prev   = 1'b0;
      pend      = 1'b0;
   endtask

   task automatic apply_ack(input int c);
      if (p_err) return;
      case (p_cmd)
         C_ACT: begin
            m_open[p_bank] = 1'b1;
            m_row[p_bank]  = p_row;
            t_act[p_bank]  = c;
         end
         C_PRE: begin
            if (m_open[p_bank]) begin
               m_open[p_bank] = 1'b0;
               t_pre[p_bank]  = c;
            end
         end
         default: begin
            t_rw_prev = t_rw;
            wr_prev   = wr_last;
            t_rw      = c;
            wr_last   = (p_cmd == C_WR);
         end
      endcase
   endtask

   // One clock: sample at the falling edge and compare every output to the model.
   task automatic step();
      bit hit, en;
      @(negedge clk);
      cur = cyc;
      hit = pend && (cur == exp_ack);
      if (hit) apply_ack(cur);
      chk("cmd_ack", 32'(bus.cmd_ack), 32'(hit));
      if (hit) chk("cmd_err", 32'(bus.cmd_err), 32'(p_err));
      chk("bank_open", 32'(bank_open), 32'(open_vec()));
      en = in_win(t_rw, cur) || in_win(t_rw_prev, cur);
      chk("data_en", 32'(data_en), 32'(en));
      if (en) chk("data_wr", 32'(data_wr), 32'(in_win(t_rw, cur) ? wr_last : wr_prev));
      chk("all_idle", 32'(all_idle), 32'((open_vec() == '0) && (cur >= t_rw + T_BURST - 1)));
      if (hit) begin
         pend        = 1'b0;
         bus.cmd_req = 1'b0;
         idle_from   = cur + 2;
      end
   endtask

   // Present a command once the timer is idle and predict its ack cycle and error flag.
   task automatic start_cmd(input logic [1:0] c, input logic [NB-1:0] bs,
                            input logic [NR-1:0] rs, input logic [NC-1:0] cs);
      bit bank_ok, row_ok, col_ok, rw;
      int n;
      while (cur < idle_from) step();
      bus.cmd_req  = 1'b1;
      bus.cmd      = c;
      bus.bank_sel = bs;
      bus.row_sel  = rs;
      bus.col_sel  = cs;
      n       = cur;
      bank_ok = ($countones(bs) == 1);
      row_ok  = ($countones(rs) == 1);
      col_ok  = ($countones(cs) == 1);
      rw      = (c == C_RD) || (c == C_WR);
      p_cmd   = c;
      p_bank  = bank_ok ? oh_idx(128'(bs)) : 0;
      p_row   = row_ok ? oh_idx(128'(rs)) : -1;
      p_err   = !bank_ok || ((c != C_PRE) && !row_ok) || (rw && !col_ok)
              || ((c == C_ACT) && m_open[p_bank])
              || (rw && !m_open[p_bank])
              || (rw && (m_row[p_bank] != p_row));
      if (p_err)            exp_ack = n + 2;
      else if (c == C_ACT)  exp_ack = imax(n + 2, t_pre[p_bank] + T_RP);
      else if (rw)          exp_ack = imax(imax(n + 2, t_act[p_bank] + T_RCD), t_rw + T_BURST);
      else if (m_open[p_bank]) exp_ack = imax(n + 2, t_act[p_bank] + T_RAS);
      else                  exp_ack = n + 2;
      pend = 1'b1;
   endtask

   task automatic issue(input logic [1:0] c, input logic [NB-1:0] bs,
                        input logic [NR-1:0] rs, input logic [NC-1:0] cs);
      start_cmd(c, bs, rs, cs);
      while (pend) step();
   endtask

   initial begin
      logic [NB-1:0] bs, two;
      logic [NR-1:0] rs;
      logic [NC-1:0] cs;
      int r;

      bus.cmd_req  = 1'b0;
      bus.cmd      = C_ACT;
      bus.bank_sel = '0;
      bus.row_sel  = '0;
      bus.col_sel  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_cmd_ack", 32'(bus.cmd_ack), 32'(0));
      chk("rst_cmd_err", 32'(bus.cmd_err), 32'(0));
      chk("rst_bank_open", 32'(bank_open), 32'(0));
      chk("rst_data_en", 32'(data_en), 32'(0));
      chk("rst_data_wr", 32'(data_wr), 32'(0));
      chk("rst_all_idle", 32'(all_idle), 32'(1));
      rst_b     = 1'b1;
      cur       = cyc;
      idle_from = cur + 1;

      // Activate, read after tRCD, precharge after tRAS, reactivate after tRP.
      issue(C_ACT, oh_b(0), oh_r(5), oh_c(0));
      issue(C_RD,  oh_b(0), oh_r(5), oh_c(3));
      issue(C_PRE, oh_b(0), '0, '0);
      issue(C_ACT, oh_b(0), oh_r(5), oh_c(0));

      // Rejected commands.
      issue(C_RD,  oh_b(2), oh_r(5), oh_c(3));
      issue(C_ACT, oh_b(0), oh_r(5), oh_c(0));
      two = NB'(3);
      issue(C_RD,  two, oh_r(5), oh_c(3));
      issue(C_RD,  oh_b(0), oh_r(6), oh_c(3));

      // Burst sharing across banks.
      issue(C_WR,  oh_b(0), oh_r(5), oh_c(1));
      issue(C_ACT, oh_b(1), oh_r(7), oh_c(0));
      issue(C_RD,  oh_b(1), oh_r(7), oh_c(0));
      issue(C_PRE, oh_b(5), '0, '0);

      // Random command mix.
      for (int k = 0; k < 200; k++) begin
         r  = $urandom_range(0, 9);
         bs = '0;
         if (r < 8)       bs[$urandom_range(0, 3)] = 1'b1;
         else if (r == 9) bs = two << $urandom_range(0, 5);
         rs = '0;
         if ($urandom_range(0, 9) != 0) rs[4 + $urandom_range(0, 2)] = 1'b1;
         else begin
            rs[3] = 1'b1;
            rs[9] = 1'b1;
         end
         cs = '0;
         if ($urandom_range(0, 9) != 0) cs[$urandom_range(0, 7)] = 1'b1;
         issue(2'($urandom_range(0, 3)), bs, rs, cs);
         repeat ($urandom_range(0, 2)) step();
      end

      // Reset while a read waits on the burst: the pending command is dropped.
      repeat (12) step();
      for (int b = 0; b < NB; b++) if (m_open[b]) issue(C_PRE, oh_b(b), '0, '0);
      issue(C_ACT, oh_b(0), oh_r(5), oh_c(0));
      issue(C_WR,  oh_b(0), oh_r(5), oh_c(2));
      start_cmd(C_RD, oh_b(0), oh_r(5), oh_c(4));
      repeat (3) step();
      chk("rd_still_pending", 32'(pend), 32'(1));
      @(negedge clk);
      rst_b       = 1'b0;
      bus.cmd_req = 1'b0;
      #1;
      chk("async_cmd_ack", 32'(bus.cmd_ack), 32'(0));
      chk("async_bank_open", 32'(bank_open), 32'(0));
      chk("async_data_en", 32'(data_en), 32'(0));
      chk("async_data_wr", 32'(data_wr), 32'(0));
      chk("async_all_idle", 32'(all_idle), 32'(1));
      model_reset();
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold_ack", 32'(bus.cmd_ack), 32'(0));
      end
      rst_b     = 1'b1;
      cur       = cyc;
      idle_from = cur + 1;
      repeat (8) step();
      issue(C_ACT, oh_b(3), oh_r(5), oh_c(0));
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
